// File: rtl/reg_pair_unit_if.sv
`default_nettype none
// ============================================================================
//  Module    : reg_pair_unit_if
//  Purpose   : Decoder-side handshake bundle for reg_pair_unit. The decoder
//              (master) issues one register-pair operation per start pulse
//              and waits for done; the sequencer (slave) reports busy, done,
//              err and the 16-bit result.
//  Signals   : start     - request, accepted only while busy=0
//              op        - 0=INC, 1=DEC, 2=LOAD imm16, 3=READ
//              pair_sel  - 0=BC, 1=DE, 2=HL, 3=illegal
//              imm16     - LOAD value, sampled with start
//              busy      - high whenever the sequencer is not idle
//              done      - one-cycle completion pulse
//              err       - illegal pair_sel seen, held until next accepted start
//              result    - new (or current, for READ) pair value
//  Revision  : 1.0 - initial release
// ============================================================================
interface reg_pair_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  pair_sel;
  logic [15:0] imm16;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;

  modport master (
    output start, op, pair_sel, imm16,
    input  busy, done, err, result
  );

  modport slave (
    input  start, op, pair_sel, imm16,
    output busy, done, err, result
  );
endinterface
`default_nettype wire

// File: rtl/reg_pair_unit.sv
`default_nettype none
// ============================================================================
//  Module    : reg_pair_unit
//  Purpose   : Sequencer for 16-bit register-pair operations (INC, DEC,
//              LOAD imm16, READ) on an 8-bit register file with two
//              combinational read ports and one write port. Each 16-bit
//              write is split into a low-byte then a high-byte write.
//  Ports     : clock          - rising-edge clock shared with register file
//              reset_n        - asynchronous active-low reset
//              dec            - decoder handshake (reg_pair_unit_if.slave)
//              rf_out1_sel    - register file read port 1 select (high byte)
//              rf_out2_sel    - register file read port 2 select (low byte)
//              rf_data_in     - register file write data
//              rf_data_in_sel - register file write select
//              rf_write_reg   - register file write enable
//              rf_out1        - register file read port 1 data
//              rf_out2        - register file read port 2 data
//  Revision  : 1.0 - initial release
// ============================================================================
module reg_pair_unit (
  input  wire        clock,
  input  wire        reset_n,
  reg_pair_unit_if.slave dec,
  output logic [2:0] rf_out1_sel,
  output logic [2:0] rf_out2_sel,
  output logic [7:0] rf_data_in,
  output logic [2:0] rf_data_in_sel,
  output logic       rf_write_reg,
  input  wire  [7:0] rf_out1,
  input  wire  [7:0] rf_out2
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_INC  = 2'd0;
  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic [1:0] PAIR_ILLEGAL = 2'd3;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  logic [1:0]  r_op;
  logic [1:0]  r_pair;
  logic [15:0] r_imm;
  logic        r_err;
  logic [15:0] r_result;

  logic [2:0]  w_hi_idx;
  logic [2:0]  w_lo_idx;
  logic [15:0] w_cur;
  logic [15:0] w_new;
  logic        w_accept;

  // Pairs map onto consecutive file slots: BC=0/1, DE=2/3, HL=4/5, so the
  // high index is 2*pair and the low index is 2*pair+1.
  assign w_hi_idx = {r_pair, 1'b0};
  assign w_lo_idx = {r_pair, 1'b1};

  assign w_accept = (r_state == S_IDLE) && dec.start;

  // File reads are combinational, so the pair is visible in READ itself.
  assign w_cur = {rf_out1, rf_out2};

  always_comb begin
    w_new = w_cur;
    case (r_op)
      OP_INC:  w_new = w_cur + 16'd1;
      OP_DEC:  w_new = w_cur - 16'd1;
      OP_LOAD: w_new = r_imm;
      OP_READ: w_new = w_cur;
      default: w_new = w_cur;
    endcase
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (dec.start) begin
          w_next_state = (dec.pair_sel == PAIR_ILLEGAL) ? S_DONE : S_READ;
        end
      end
      S_READ:  w_next_state = (r_op == OP_READ) ? S_DONE : S_WR_LO;
      S_WR_LO: w_next_state = S_WR_HI;
      S_WR_HI: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  // Register-file controls decode straight from state so an asynchronous
  // reset drops the write enable in the same instant.
  always_comb begin
    rf_out1_sel    = 3'd0;
    rf_out2_sel    = 3'd0;
    rf_data_in     = 8'd0;
    rf_data_in_sel = 3'd0;
    rf_write_reg   = 1'b0;
    case (r_state)
      S_READ: begin
        rf_out1_sel = w_hi_idx;
        rf_out2_sel = w_lo_idx;
      end
      S_WR_LO: begin
        rf_write_reg   = 1'b1;
        rf_data_in_sel = w_lo_idx;
        rf_data_in     = r_result[7:0];
      end
      S_WR_HI: begin
        rf_write_reg   = 1'b1;
        rf_data_in_sel = w_hi_idx;
        rf_data_in     = r_result[15:8];
      end
      default: begin
      end
    endcase
  end

  assign dec.busy   = (r_state != S_IDLE);
  assign dec.done   = (r_state == S_DONE);
  assign dec.err    = r_err;
  assign dec.result = r_result;

  // ------------------------------------------------------------- datapath
  // Operands are captured only on an accepted start, so start pulses while
  // busy cannot disturb an operation in flight. The computed value doubles
  // as the write-data source for both byte writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= OP_INC;
      r_pair   <= 2'd0;
      r_imm    <= 16'd0;
      r_err    <= 1'b0;
      r_result <= 16'd0;
    end else if (w_accept) begin
      r_op   <= dec.op;
      r_pair <= dec.pair_sel;
      r_imm  <= dec.imm16;
      r_err  <= (dec.pair_sel == PAIR_ILLEGAL);
      if (dec.pair_sel == PAIR_ILLEGAL) begin
        r_result <= 16'd0;
      end
    end else if (r_state == S_READ) begin
      r_result <= w_new;
    end
  end

endmodule
`default_nettype wire
